// File: rtl/platform_field.sv
// platform_field: Doodle Jump platform slots - per-frame scroll, landing and recycle; per-pixel colour.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module platform_field #(
  parameter int          N_PLATFORMS = 8,
  parameter int          X_W         = 11,
  parameter int          Y_W         = 10,
  parameter int          SCREEN_W    = 1280,
  parameter int          SCREEN_H    = 720,
  parameter int          PLAT_W      = 96,
  parameter int          PLAT_H      = 16,
  parameter int          DOODLE_W    = 64,
  parameter int          SCROLL_LINE = 240,
  parameter int          MAX_SCROLL  = 15,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 frame_tick_i,
  input  logic [X_W-1:0]       doodle_x_i,
  input  logic [Y_W-1:0]       doodle_y_i,
  input  logic                 doodle_falling_i,
  input  logic [X_W-1:0]       beam_x_i,
  input  logic [Y_W-1:0]       beam_y_i,
  output logic                 busy_o,
  output logic [3:0]           scroll_dy_o,
  output logic                 collision_o,
  output logic [Y_W-1:0]       ground_o,
  output logic [15:0]          score_o,
  output logic [2:0][3:0]      color_o,
  output logic                 is_transparent_o
);

  localparam int                IDX_W    = $clog2(N_PLATFORMS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_PLATFORMS - 1);
  localparam logic [X_W-1:0]    X_MOD    = X_W'(SCREEN_W - PLAT_W);
  localparam logic [Y_W-1:0]    SCROLL_Y = Y_W'(SCROLL_LINE);
  localparam logic [Y_W-1:0]    MAX_Y    = Y_W'(MAX_SCROLL);
  localparam logic [3:0]        MAX_S    = 4'(MAX_SCROLL);
  localparam logic [2:0][3:0]   GREEN    = {4'h2, 4'hC, 4'h2};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCROLL  = 2'd1,
    S_COLLIDE = 2'd2,
    S_RESPAWN = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [X_W-1:0]     x_q [N_PLATFORMS];
  logic [Y_W-1:0]     y_q [N_PLATFORMS];
  logic [X_W-1:0]     dx_q;
  logic [Y_W-1:0]     dy_q;
  logic               falling_q;
  logic [3:0]         scroll_q;
  logic               busy_q;
  logic               coll_q;
  logic [Y_W-1:0]     ground_q;
  logic [15:0]        score_q;
  logic [15:0]        lfsr_q;
  logic               transp_q;
  logic [2:0][3:0]    color_q;

  logic [3:0]         scroll_d;
  logic [Y_W-1:0]     gap;
  logic [15:0]        lfsr_d;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [Y_W-1:0]     scrolled_y;
  logic [Y_W:0]       feet;
  logic [Y_W:0]       plat_bot;
  logic [X_W:0]       doodle_r;
  logic [X_W:0]       plat_r;
  logic               hit;
  logic               offscreen;
  logic [Y_W-1:0]     wrapped_y;
  logic [X_W-1:0]     rnd_x;
  logic               last;
  logic               pix_hit;

  always_comb begin
    scroll_d = '0;
    gap      = '0;
    if (doodle_y_i < SCROLL_Y) begin
      gap      = SCROLL_Y - doodle_y_i;
      scroll_d = (gap > MAX_Y) ? MAX_S : gap[3:0];
    end
  end

  assign sel_x      = x_q[idx_q];
  assign sel_y      = y_q[idx_q];
  assign last       = (idx_q == IDX_LAST);
  assign scrolled_y = sel_y + Y_W'(scroll_q);

  // Feet are compared after the scroll so the doodle moves with the field.
  assign feet     = {1'b0, dy_q} + (Y_W+1)'(scroll_q);
  assign plat_bot = {1'b0, sel_y} + (Y_W+1)'(PLAT_H);
  assign doodle_r = {1'b0, dx_q} + (X_W+1)'(DOODLE_W);
  assign plat_r   = {1'b0, sel_x} + (X_W+1)'(PLAT_W);
  assign hit      = falling_q
                    && (doodle_r > {1'b0, sel_x})
                    && ({1'b0, dx_q} < plat_r)
                    && ({1'b0, sel_y} <= feet)
                    && (feet < plat_bot);

  assign offscreen = ({1'b0, sel_y} >= (Y_W+1)'(SCREEN_H));
  assign wrapped_y = sel_y - Y_W'(SCREEN_H);
  assign rnd_x     = lfsr_q[X_W-1:0] % X_MOD;
  assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      falling_q <= 1'b0;
      scroll_q  <= '0;
      busy_q    <= 1'b0;
      coll_q    <= 1'b0;
      ground_q  <= Y_W'(SCREEN_H);
      score_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      for (int i = 0; i < N_PLATFORMS; i++) begin
        y_q[i] <= Y_W'(SCREEN_H - PLAT_H - i * (SCREEN_H / N_PLATFORMS));
        x_q[i] <= X_W'((i * 160) % (SCREEN_W - PLAT_W));
      end
    end else begin
      coll_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy drops one cycle after the last slot so the frame spans 3N+1 cycles.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (frame_tick_i) begin
            dx_q      <= doodle_x_i;
            dy_q      <= doodle_y_i;
            falling_q <= doodle_falling_i;
            scroll_q  <= scroll_d;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            state_q   <= S_SCROLL;
          end
        end
        S_SCROLL: begin
          y_q[idx_q] <= scrolled_y;
          if (last) begin
            idx_q   <= '0;
            state_q <= S_COLLIDE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_COLLIDE: begin
          if (hit) begin
            coll_q   <= 1'b1;
            ground_q <= sel_y;
            idx_q    <= '0;
            state_q  <= S_RESPAWN;
          end else if (last) begin
            idx_q   <= '0;
            state_q <= S_RESPAWN;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_RESPAWN: begin
          if (offscreen) begin
            y_q[idx_q] <= wrapped_y;
            x_q[idx_q] <= rnd_x;
            lfsr_q     <= lfsr_d;
            if (score_q != 16'hFFFF) begin
              score_q <= score_q + 16'd1;
            end
          end
          if (last) begin
            idx_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < N_PLATFORMS; i++) begin
      if ((x_q[i] <= beam_x_i)
          && ({1'b0, beam_x_i} < ({1'b0, x_q[i]} + (X_W+1)'(PLAT_W)))
          && (y_q[i] <= beam_y_i)
          && ({1'b0, beam_y_i} < ({1'b0, y_q[i]} + (Y_W+1)'(PLAT_H)))) begin
        pix_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      transp_q <= 1'b1;
      color_q  <= '0;
    end else begin
      transp_q <= !pix_hit;
      color_q  <= pix_hit ? GREEN : '0;
    end
  end

  assign busy_o           = busy_q;
  assign scroll_dy_o      = scroll_q;
  assign collision_o      = coll_q;
  assign ground_o         = ground_q;
  assign score_o          = score_q;
  assign color_o          = color_q;
  assign is_transparent_o = transp_q;

endmodule

`default_nettype wire

// File: tb/tb_platform_field.sv
// tb_platform_field: directed, table-driven checks of platform_field frame updates and pixel path.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_platform_field;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_tick;
  logic [10:0]       doodle_x;
  logic [9:0]        doodle_y;
  logic              doodle_falling;
  logic [10:0]       beam_x;
  logic [9:0]        beam_y;
  logic              busy;
  logic [3:0]        scroll_dy;
  logic              collision;
  logic [9:0]        ground;
  logic [15:0]       score;
  logic [2:0][3:0]   color;
  logic              is_transparent;

  always #5 clk = ~clk;

  platform_field dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .frame_tick_i     (frame_tick),
    .doodle_x_i       (doodle_x),
    .doodle_y_i       (doodle_y),
    .doodle_falling_i (doodle_falling),
    .beam_x_i         (beam_x),
    .beam_y_i         (beam_y),
    .busy_o           (busy),
    .scroll_dy_o      (scroll_dy),
    .collision_o      (collision),
    .ground_o         (ground),
    .score_o          (score),
    .color_o          (color),
    .is_transparent_o (is_transparent)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [10:0] dx;
    logic [9:0]  dy;
    logic        fall;
    int          exp_s;
    int          exp_ncoll;
    int          exp_ground;
    int          exp_score;
    int          exp_busy;
  } frame_t;

  typedef struct {
    int   phase;
    int   bx;
    int   by;
    logic exp_tr;
  } probe_t;

  frame_t frames[14];
  probe_t probes[$];

  task automatic probe(input int bx, input int by, input logic exp_tr, input string tag);
    logic [11:0] exp_col;
    @(negedge clk);
    beam_x = 11'(bx);
    beam_y = 10'(by);
    @(negedge clk);
    exp_col = exp_tr ? 12'h000 : 12'h2C2;
    check($sformatf("%s transparent@(%0d,%0d)", tag, bx, by), {31'd0, is_transparent}, {31'd0, exp_tr});
    check($sformatf("%s color@(%0d,%0d)", tag, bx, by), {20'd0, color}, {20'd0, exp_col});
  endtask

  task automatic run_frame(input logic [10:0] dx, input logic [9:0] dy, input logic f,
                           output int busy_n, output int coll_n, output int ground_seen);
    @(negedge clk);
    doodle_x       = dx;
    doodle_y       = dy;
    doodle_falling = f;
    frame_tick     = 1'b1;
    @(negedge clk);
    frame_tick  = 1'b0;
    busy_n      = 0;
    coll_n      = 0;
    ground_seen = -1;
    while (busy === 1'b1 && busy_n < 200) begin
      if (collision === 1'b1) begin
        coll_n++;
        ground_seen = int'(ground);
      end
      busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic run_probes(input int phase);
    foreach (probes[k]) begin
      if (probes[k].phase == phase)
        probe(probes[k].bx, probes[k].by, probes[k].exp_tr, $sformatf("ph%0d", phase));
    end
  endtask

  initial begin
    int bn, cn, gs;
    int coll_seen;

    //            dx     dy    fall  s  ncoll ground score busy
    frames[0]  = '{11'd600, 10'd500, 1'b0, 0,  0, 720, 0, 25};
    frames[1]  = '{11'd40,  10'd708, 1'b0, 0,  0, 720, 0, 25};
    frames[2]  = '{11'd40,  10'd708, 1'b1, 0,  1, 704, 0, 18};
    frames[3]  = '{11'd600, 10'd500, 1'b0, 0,  0, 704, 0, 25};
    frames[4]  = '{11'd600, 10'd235, 1'b0, 5,  0, 704, 0, 25};
    frames[5]  = '{11'd600, 10'd239, 1'b0, 1,  0, 704, 0, 25};
    frames[6]  = '{11'd600, 10'd240, 1'b0, 0,  0, 704, 0, 25};
    frames[7]  = '{11'd600, 10'd225, 1'b0, 15, 0, 704, 1, 25};
    for (int k = 8; k < 13; k++) frames[k] = '{11'd600, 10'd225, 1'b0, 15, 0, 704, 1, 25};
    frames[13] = '{11'd600, 10'd225, 1'b0, 15, 0, 704, 2, 25};

    probes.push_back('{-1, 0,    704, 1'b0});
    probes.push_back('{-1, 0,    703, 1'b1});
    probes.push_back('{-1, 95,   719, 1'b0});
    probes.push_back('{-1, 96,   719, 1'b1});
    probes.push_back('{-1, 160,  614, 1'b0});
    probes.push_back('{-1, 160,  613, 1'b1});
    probes.push_back('{-1, 1215, 89,  1'b0});
    probes.push_back('{-1, 1216, 89,  1'b1});
    probes.push_back('{6,  0,    710, 1'b0});
    probes.push_back('{6,  0,    709, 1'b1});
    probes.push_back('{7,  65,   5,   1'b0});
    probes.push_back('{7,  64,   5,   1'b1});
    probes.push_back('{7,  160,  5,   1'b0});
    probes.push_back('{7,  161,  5,   1'b1});
    probes.push_back('{7,  65,   4,   1'b1});
    probes.push_back('{7,  65,   20,  1'b0});
    probes.push_back('{7,  65,   21,  1'b1});
    probes.push_back('{7,  0,    710, 1'b1});
    probes.push_back('{13, 65,   95,  1'b0});
    probes.push_back('{13, 65,   94,  1'b1});
    probes.push_back('{13, 464,  5,   1'b0});
    probes.push_back('{13, 463,  5,   1'b1});
    probes.push_back('{13, 559,  20,  1'b0});
    probes.push_back('{13, 560,  20,  1'b1});

    rst_n          = 1'b0;
    frame_tick     = 1'b0;
    doodle_x       = '0;
    doodle_y       = '0;
    doodle_falling = 1'b0;
    beam_x         = '0;
    beam_y         = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset busy",      {31'd0, busy},           0);
    check("reset scroll_dy", {28'd0, scroll_dy},      0);
    check("reset collision", {31'd0, collision},      0);
    check("reset score",     {16'd0, score},          0);
    check("reset ground",    {22'd0, ground},         720);
    check("reset transp",    {31'd0, is_transparent}, 1);
    check("reset color",     {20'd0, color},          0);

    run_probes(-1);

    for (int f = 0; f < 14; f++) begin
      run_frame(frames[f].dx, frames[f].dy, frames[f].fall, bn, cn, gs);
      check($sformatf("frame%0d busy_cycles", f), bn, frames[f].exp_busy);
      check($sformatf("frame%0d scroll_dy", f), {28'd0, scroll_dy}, frames[f].exp_s);
      check($sformatf("frame%0d collisions", f), cn, frames[f].exp_ncoll);
      if (frames[f].exp_ncoll != 0)
        check($sformatf("frame%0d ground_at_pulse", f), gs, frames[f].exp_ground);
      check($sformatf("frame%0d ground", f), {22'd0, ground}, frames[f].exp_ground);
      check($sformatf("frame%0d score", f), {16'd0, score}, frames[f].exp_score);
      run_probes(f);
    end

    // Extra ticks mid-frame and on the final busy cycle must both be ignored.
    @(negedge clk);
    doodle_x = 11'd600; doodle_y = 10'd500; doodle_falling = 1'b0; frame_tick = 1'b1;
    bn = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bn++;
      frame_tick = (c == 5 || c == 25);
      if (c == 5 || c == 25) doodle_y = 10'd200;
      else doodle_y = 10'd500;
    end
    frame_tick = 1'b0;
    check("ignored_tick busy_cycles", bn, 25);
    check("ignored_tick scroll_dy", {28'd0, scroll_dy}, 0);
    check("ignored_tick busy_low", {31'd0, busy}, 0);
    check("ignored_tick score", {16'd0, score}, 2);
    probe(65, 95, 1'b0, "ignored_tick");

    // Asynchronous reset while the field is about to register a landing on slot 0.
    @(negedge clk);
    doodle_x = 11'd65; doodle_y = 10'd100; doodle_falling = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    coll_seen = 0;
    for (int c = 2; c <= 9; c++) begin
      if (collision === 1'b1) coll_seen++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midreset busy",      {31'd0, busy},           0);
    check("midreset collision", {31'd0, collision},      0);
    check("midreset score",     {16'd0, score},          0);
    check("midreset ground",    {22'd0, ground},         720);
    check("midreset scroll_dy", {28'd0, scroll_dy},      0);
    check("midreset transp",    {31'd0, is_transparent}, 1);
    repeat (2) begin
      @(negedge clk);
      if (collision === 1'b1) coll_seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (collision === 1'b1) coll_seen++;
    end
    check("midreset no_pulse", coll_seen, 0);
    check("midreset idle", {31'd0, busy}, 0);
    probe(0, 704, 1'b0, "midreset");
    probe(65, 95, 1'b1, "midreset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
